pattern_seq_ctrl: RTL and testbench
===================================

PATTERN_SEQ_CTRL -- requirements
Module: pattern_seq_ctrl

Interface
REQ-001 The block SHALL have parameter _PAT_WIDTH, default 8: pattern width, equal to the driven pattern_pwm's _PAT_WIDTH.
REQ-002 The block SHALL have parameter _DEPTH, default 4: number of sequence table entries, power of two, 2..16.
REQ-003 The block SHALL use one clock and a synchronous active-low reset, ports named clk and rst_n: clk input 1 (only clock); rst_n input 1 (synchronous reset, active low).
REQ-004 The block SHALL have these control ports: seq_start input 1 (start pulse); seq_stop input 1 (graceful stop pulse); seq_loop input 1 (restart at entry 0 after last entry); seq_last input log2(_DEPTH) (index of last entry, sampled on start).
REQ-005 The block SHALL have these table-write ports: cfg_we input 1; cfg_addr input log2(_DEPTH); cfg_pat input _PAT_WIDTH; cfg_duty input 8; cfg_rep input 8 (repetitions, 0 = skip entry).
REQ-006 The block SHALL have these pattern_pwm-side ports: pwm_en output 1; pat output _PAT_WIDTH; duty_num output 8; pwm_busy input 1; pwm_valid input 1.
REQ-007 The block SHALL have these status ports: seq_busy output 1; seq_done output 1 (one-cycle pulse); cur_idx output log2(_DEPTH); cfg_err output 1 (one-cycle pulse).

Function
REQ-008 The block SHALL hold a table of _DEPTH entries {pat, duty, rep} in registers.
REQ-009 A write with cfg_we=1 SHALL update entry cfg_addr on the next edge only in IDLE; a write in any other state SHALL be dropped and SHALL pulse cfg_err the next cycle.
REQ-010 The FSM SHALL have the states IDLE, SEL, FIRE, ARM, RUN, NEXT.
REQ-011 IDLE: seq_start=1 with seq_stop=0 SHALL latch seq_last and seq_loop, clear cur_idx and fired flag, and go to SEL; seq_start while not IDLE SHALL be ignored.
REQ-012 SEL: if rep[cur_idx]=0, go to NEXT; otherwise load rep_cnt=rep[cur_idx] and go to FIRE.
REQ-013 FIRE: pwm_en=1 for exactly one cycle, set fired flag, go to ARM.
REQ-014 ARM: wait for pwm_busy=1, then go to RUN.
REQ-015 RUN: on pwm_valid=1, decrement rep_cnt; if the result is nonzero and no stop is pending, go to FIRE (re-fire after pwm_busy=0); otherwise go to NEXT.
REQ-016 FIRE SHALL NOT assert pwm_en while pwm_busy=1; in that case it SHALL hold until pwm_busy=0.
REQ-017 NEXT, when a stop is pending: pulse seq_done and go to IDLE.
REQ-018 NEXT, when cur_idx<seq_last: cur_idx+1, go to SEL.
REQ-019 NEXT, when cur_idx=seq_last with loop=1 and fired=1: cur_idx=0, clear fired, go to SEL.
REQ-020 NEXT, in all other cases: pulse seq_done and go to IDLE.
REQ-021 A table whose entries all have rep=0 SHALL terminate with seq_done after one pass, even with loop=1.
REQ-022 pat and duty_num SHALL be registered from entry cur_idx and SHALL be stable from FIRE until leaving RUN.
REQ-023 seq_stop in any non-IDLE state SHALL set stop_pending; the current pattern SHALL complete (wait for pwm_valid), then the FSM goes to NEXT and ends.
REQ-024 seq_stop in SEL or FIRE SHALL end via NEXT without firing.
REQ-025 seq_stop in IDLE SHALL have no effect.
REQ-026 seq_start and seq_stop together in IDLE: stop wins and the start is ignored.
REQ-027 seq_busy SHALL be 1 in every state except IDLE.
REQ-028 seq_done SHALL assert in the same cycle that seq_busy falls.
REQ-029 rep_cnt SHALL be 8 bits, non-wrapping; rep=255 SHALL yield exactly 255 firings.
REQ-030 cur_idx SHALL wrap only via loop and never exceed seq_last.

Reset
REQ-031 With rst_n=0 at a clk edge, the FSM SHALL go to IDLE and pwm_en, seq_busy, seq_done, cfg_err, cur_idx, pat, duty_num, rep_cnt, stop_pending and fired SHALL be 0.
REQ-032 Reset SHALL clear all table entries to 0.
REQ-033 A reset mid-sequence SHALL take effect at that edge with no seq_done pulse.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (3-bit constants) and the default _PAT_WIDTH/_DEPTH.
REQ-035 There SHALL be no sub-module; pattern_pwm is instantiated beside this block at top level, not inside it.

Verification
REQ-036 Entry0={pat 8'b00000101, duty 3, rep 2}, seq_last=0, start -> exactly 2 pwm_en pulses, each after pwm_busy=0, then one seq_done, seq_busy=0.
REQ-037 Entries 0..2 with rep {1,0,3}, seq_last=2 -> 4 firings total, entry 1 skipped, cur_idx sequence 0,1,2.
REQ-038 loop=1, entries 0..1 rep {1,1}, seq_stop during entry 1's first RUN -> entry 1 completes, seq_done, no return to entry 0.
REQ-039 All rep=0, loop=1, start -> seq_done within 2*_DEPTH+4 cycles, no pwm_en.
REQ-040 cfg_we during RUN -> cfg_err pulse, table unchanged (read back via the next run's pat).
REQ-041 rst_n=0 asserted during ARM -> next cycle all outputs 0, the FSM is in IDLE, and a new start runs normally.

Source files
------------

// File: rtl/pattern_seq_ctrl_pkg.sv
// Shared definitions for the pattern sequencer: default geometry and FSM state encoding.
package pattern_seq_ctrl_pkg;

    localparam int DEF_PAT_WIDTH = 8;
    localparam int DEF_DEPTH     = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_FIRE = 3'd2,
        ST_ARM  = 3'd3,
        ST_RUN  = 3'd4,
        ST_NEXT = 3'd5
    } seq_state_t;

endpackage

// File: rtl/pattern_seq_ctrl.sv
// Walks a small {pattern, duty, repeat} table and fires an external pattern_pwm
// once per repetition, with optional looping and a graceful stop.
module pattern_seq_ctrl
    import pattern_seq_ctrl_pkg::*;
#(
    parameter int _PAT_WIDTH = DEF_PAT_WIDTH,
    parameter int _DEPTH     = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       seq_start,
    input  logic                       seq_stop,
    input  logic                       seq_loop,
    input  logic [$clog2(_DEPTH)-1:0]  seq_last,
    input  logic                       cfg_we,
    input  logic [$clog2(_DEPTH)-1:0]  cfg_addr,
    input  logic [_PAT_WIDTH-1:0]      cfg_pat,
    input  logic [7:0]                 cfg_duty,
    input  logic [7:0]                 cfg_rep,
    output logic                       pwm_en,
    output logic [_PAT_WIDTH-1:0]      pat,
    output logic [7:0]                 duty_num,
    input  logic                       pwm_busy,
    input  logic                       pwm_valid,
    output logic                       seq_busy,
    output logic                       seq_done,
    output logic [$clog2(_DEPTH)-1:0]  cur_idx,
    output logic                       cfg_err
);

    localparam int IW = $clog2(_DEPTH);

    seq_state_t             state, state_nxt;
    logic [_PAT_WIDTH-1:0]  tab_pat  [_DEPTH];
    logic [7:0]             tab_duty [_DEPTH];
    logic [7:0]             tab_rep  [_DEPTH];
    logic [IW-1:0]          last_q, idx_nxt;
    logic                   loop_q, fired, fired_nxt, stop_pending, stop_now;
    logic [7:0]             rep_cnt, rep_cnt_nxt;
    logic                   done_nxt, load_entry;

    // A stop arriving this very cycle counts, so SEL/FIRE can bail out without firing.
    assign stop_now = stop_pending | seq_stop;

    always_comb begin
        state_nxt   = state;
        idx_nxt     = cur_idx;
        fired_nxt   = fired;
        rep_cnt_nxt = rep_cnt;
        done_nxt    = 1'b0;
        pwm_en      = 1'b0;
        load_entry  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (seq_start && !seq_stop) begin
                    idx_nxt   = '0;
                    fired_nxt = 1'b0;
                    state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                if (stop_now || tab_rep[cur_idx] == 8'd0) begin
                    state_nxt = ST_NEXT;
                end else begin
                    rep_cnt_nxt = tab_rep[cur_idx];
                    load_entry  = 1'b1;
                    state_nxt   = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (stop_now) begin
                    state_nxt = ST_NEXT;
                end else if (!pwm_busy) begin
                    pwm_en    = 1'b1;
                    fired_nxt = 1'b1;
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (pwm_busy) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (pwm_valid) begin
                    if (rep_cnt != 8'd0) rep_cnt_nxt = rep_cnt - 8'd1;
                    state_nxt = (rep_cnt > 8'd1 && !stop_now) ? ST_FIRE : ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (stop_now) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cur_idx < last_q) begin
                    idx_nxt   = cur_idx + 1'b1;
                    state_nxt = ST_SEL;
                end else if (loop_q && fired) begin
                    // Loop only if the pass fired at least once; an all-skip table ends.
                    idx_nxt   = '0;
                    fired_nxt = 1'b0;
                    state_nxt = ST_SEL;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cur_idx      <= '0;
            last_q       <= '0;
            loop_q       <= 1'b0;
            fired        <= 1'b0;
            stop_pending <= 1'b0;
            rep_cnt      <= '0;
            pat          <= '0;
            duty_num     <= '0;
            seq_busy     <= 1'b0;
            seq_done     <= 1'b0;
            cfg_err      <= 1'b0;
            for (int i = 0; i < _DEPTH; i++) begin
                tab_pat[i]  <= '0;
                tab_duty[i] <= '0;
                tab_rep[i]  <= '0;
            end
        end else begin
            state    <= state_nxt;
            cur_idx  <= idx_nxt;
            fired    <= fired_nxt;
            rep_cnt  <= rep_cnt_nxt;
            seq_busy <= (state_nxt != ST_IDLE);
            seq_done <= done_nxt;
            cfg_err  <= cfg_we && (state != ST_IDLE);
            if (state_nxt == ST_IDLE) stop_pending <= 1'b0;
            else if (seq_stop)        stop_pending <= 1'b1;
            if (state == ST_IDLE) begin
                if (seq_start && !seq_stop) begin
                    last_q <= seq_last;
                    loop_q <= seq_loop;
                end
                if (cfg_we) begin
                    tab_pat[cfg_addr]  <= cfg_pat;
                    tab_duty[cfg_addr] <= cfg_duty;
                    tab_rep[cfg_addr]  <= cfg_rep;
                end
            end
            if (load_entry) begin
                pat      <= tab_pat[cur_idx];
                duty_num <= tab_duty[cur_idx];
            end
        end
    end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Scoreboard bench for pattern_seq_ctrl with a behavioural pattern_pwm stand-in.
module tb_pattern_seq_ctrl;
    import pattern_seq_ctrl_pkg::*;

    localparam int PW = DEF_PAT_WIDTH;
    localparam int D  = DEF_DEPTH;
    localparam int IW = $clog2(D);

    typedef struct {
        bit            is_done;
        logic [PW-1:0] pat;
        logic [7:0]    duty;
        logic [IW-1:0] idx;
    } exp_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          seq_start = 1'b0, seq_stop = 1'b0, seq_loop = 1'b0, cfg_we = 1'b0;
    logic [IW-1:0] seq_last = '0, cfg_addr = '0;
    logic [PW-1:0] cfg_pat = '0;
    logic [7:0]    cfg_duty = '0, cfg_rep = '0;
    logic          pwm_en, seq_busy, seq_done, cfg_err;
    logic [PW-1:0] pat;
    logic [7:0]    duty_num;
    logic [IW-1:0] cur_idx;
    logic          pwm_busy = 1'b0, pwm_valid = 1'b0, in_tail = 1'b0;
    int            run_cnt = 0, tail_cnt = 0;

    int            checks = 0, errors = 0, fire_cnt = 0;
    exp_t          exp_q[$];
    logic [PW-1:0] last_pat = '0;
    logic [7:0]    last_duty = '0;
    logic [PW-1:0] m_pat  [D];
    logic [7:0]    m_duty [D];
    logic [7:0]    m_rep  [D];

    always #5 clk = ~clk;

    pattern_seq_ctrl #(._PAT_WIDTH(PW), ._DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .seq_start(seq_start), .seq_stop(seq_stop), .seq_loop(seq_loop), .seq_last(seq_last),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pat(cfg_pat), .cfg_duty(cfg_duty), .cfg_rep(cfg_rep),
        .pwm_en(pwm_en), .pat(pat), .duty_num(duty_num), .pwm_busy(pwm_busy), .pwm_valid(pwm_valid),
        .seq_busy(seq_busy), .seq_done(seq_done), .cur_idx(cur_idx), .cfg_err(cfg_err)
    );

    // pattern_pwm stand-in: random run length, valid pulse, then random busy tail.
    always @(posedge clk) begin
        pwm_valid <= 1'b0;
        if (!rst_n) begin
            pwm_busy <= 1'b0;
            in_tail  <= 1'b0;
        end else if (!pwm_busy) begin
            if (pwm_en) begin
                pwm_busy <= 1'b1;
                in_tail  <= 1'b0;
                run_cnt  <= $urandom_range(3, 0);
                tail_cnt <= $urandom_range(2, 0);
            end
        end else if (!in_tail) begin
            if (run_cnt > 0) run_cnt <= run_cnt - 1;
            else begin
                pwm_valid <= 1'b1;
                in_tail   <= 1'b1;
                if (tail_cnt == 0) pwm_busy <= 1'b0;
            end
        end else if (tail_cnt > 1) tail_cnt <= tail_cnt - 1;
        else pwm_busy <= 1'b0;
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=<nothing>", name, act);
    endtask

    // Monitor: every pwm_en and seq_done must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pwm_en) begin
                exp_t e;
                fire_cnt++;
                check_eq("en_while_busy", {63'd0, pwm_busy}, 64'd0);
                if (exp_q.size() == 0) fail_now("unexpected_fire", {cur_idx, duty_num, pat});
                else begin
                    e = exp_q.pop_front();
                    if (e.is_done) fail_now("fire_instead_of_done", {cur_idx, duty_num, pat});
                    else check_eq("fire_idx_duty_pat", {cur_idx, duty_num, pat}, {e.idx, e.duty, e.pat});
                end
                last_pat  = pat;
                last_duty = duty_num;
            end
            if (pwm_valid) check_eq("pat_duty_stable", {duty_num, pat}, {last_duty, last_pat});
            if (seq_done) begin
                exp_t e;
                if (exp_q.size() == 0) fail_now("unexpected_done", {63'd0, seq_done});
                else begin
                    e = exp_q.pop_front();
                    if (!e.is_done) fail_now("done_before_fire", {e.idx, e.duty, e.pat});
                    else check_eq("busy_at_done", {63'd0, seq_busy}, 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int p, input int d, input int r);
        cfg_we = 1'b1; cfg_addr = a[IW-1:0]; cfg_pat = p[PW-1:0];
        cfg_duty = d[7:0]; cfg_rep = r[7:0];
        tick();
        cfg_we = 1'b0;
        m_pat[a] = p[PW-1:0]; m_duty[a] = d[7:0]; m_rep[a] = r[7:0];
    endtask

    // Reference: entries 0..last in order, each rep times; whole pass repeats when
    // looping and something fired; a stop after firing n truncates the list at n.
    task automatic push_expect(input int last, input bit loop, input int nstop);
        int n = 0;
        bit any = 0, fin = 0;
        exp_t e;
        for (int i = 0; i <= last; i++) if (m_rep[i] != 8'd0) any = 1;
        while (!fin) begin
            for (int i = 0; i <= last; i++)
                for (int r = 0; r < int'(m_rep[i]); r++)
                    if (!fin) begin
                        e.is_done = 0; e.pat = m_pat[i]; e.duty = m_duty[i]; e.idx = i[IW-1:0];
                        exp_q.push_back(e);
                        n++;
                        if (nstop > 0 && n >= nstop) fin = 1;
                    end
            if (!(loop && any)) fin = 1;
        end
        e.is_done = 1; e.pat = '0; e.duty = '0; e.idx = '0;
        exp_q.push_back(e);
    endtask

    task automatic start_seq(input int last, input bit loop);
        seq_last = last[IW-1:0]; seq_loop = loop; seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < D; i++) begin m_pat[i] = '0; m_duty[i] = '0; m_rep[i] = '0; end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while ((exp_q.size() != 0 || seq_busy) && k < budget) begin tick(); k++; end
        if (exp_q.size() != 0 || seq_busy) begin
            fail_now(name, exp_q.size());
            do_reset();
        end
    endtask

    task automatic wait_fire(input int target, output bit ok);
        int k = 0;
        while (fire_cnt < target && k < 3000) begin tick(); k++; end
        ok = (fire_cnt >= target);
        if (!ok) fail_now("fire_wait_timeout", fire_cnt);
    endtask

    // Stop lands in the first RUN cycle of the target firing.
    task automatic stop_in_run(input int target);
        bit ok;
        int k = 0;
        wait_fire(target, ok);
        if (ok) begin
            while (!pwm_busy && k < 50) begin tick(); k++; end
            tick();
            seq_stop = 1'b1;
            tick();
            seq_stop = 1'b0;
        end
    endtask

    task automatic run_case(input int last, input bit loop, input int nstop, input string name);
        int base;
        push_expect(last, loop, nstop);
        base = fire_cnt;
        start_seq(last, loop);
        if (nstop > 0) stop_in_run(base + nstop);
        wait_idle(5000, name);
    endtask

    initial begin
        bit ok;
        int base, last, total, nstop;
        bit loop;
        for (int i = 0; i < D; i++) begin m_pat[i] = '0; m_duty[i] = '0; m_rep[i] = '0; end
        repeat (3) tick();
        check_eq("rst_pwm_en", {63'd0, pwm_en}, 64'd0);
        check_eq("rst_busy", {63'd0, seq_busy}, 64'd0);
        check_eq("rst_done", {63'd0, seq_done}, 64'd0);
        check_eq("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
        check_eq("rst_idx_duty_pat", {cur_idx, duty_num, pat}, 64'd0);
        rst_n = 1'b1;
        tick();

        wr(0, 8'b0000_0101, 3, 2);
        check_eq("cfg_err_idle_write", {63'd0, cfg_err}, 64'd0);
        run_case(0, 0, 0, "two_firings");

        wr(0, 8'h11, 10, 1); wr(1, 8'h22, 20, 0); wr(2, 8'h33, 30, 3);
        run_case(2, 0, 0, "skip_entry");

        wr(0, 8'h44, 40, 1); wr(1, 8'h55, 50, 1);
        run_case(1, 1, 2, "loop_stop");

        for (int a = 0; a < D; a++) wr(a, 8'h66 + a, a, 0);
        push_expect(D - 1, 1, 0);
        start_seq(D - 1, 1);
        wait_idle(2 * D + 4, "all_zero_done_time");

        // Start and stop together in IDLE: nothing should happen.
        wr(0, 8'h77, 7, 3);
        seq_last = '0; seq_start = 1'b1; seq_stop = 1'b1;
        tick();
        seq_start = 1'b0; seq_stop = 1'b0;
        tick();
        check_eq("start_stop_idle_busy", {63'd0, seq_busy}, 64'd0);

        // Stop while in SEL ends without firing.
        push_expect(0, 0, 0);
        exp_q.delete();
        begin
            exp_t e;
            e.is_done = 1; e.pat = '0; e.duty = '0; e.idx = '0;
            exp_q.push_back(e);
        end
        start_seq(0, 0);
        seq_stop = 1'b1;
        tick();
        seq_stop = 1'b0;
        wait_idle(50, "stop_in_sel");

        // Table write while running is dropped and flagged.
        wr(0, 8'hA5, 9, 2);
        push_expect(0, 0, 0);
        base = fire_cnt;
        start_seq(0, 0);
        wait_fire(base + 1, ok);
        cfg_we = 1'b1; cfg_addr = '0; cfg_pat = 8'h5A; cfg_duty = 8'd1; cfg_rep = 8'd1;
        tick();
        cfg_we = 1'b0;
        check_eq("cfg_err_pulse", {63'd0, cfg_err}, 64'd1);
        tick();
        check_eq("cfg_err_one_cycle", {63'd0, cfg_err}, 64'd0);
        wait_idle(5000, "cfg_err_run");
        run_case(0, 0, 0, "table_unchanged");

        // Reset during ARM.
        push_expect(0, 0, 0);
        base = fire_cnt;
        start_seq(0, 0);
        wait_fire(base + 1, ok);
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check_eq("arm_rst_pwm_en", {63'd0, pwm_en}, 64'd0);
        check_eq("arm_rst_busy", {63'd0, seq_busy}, 64'd0);
        check_eq("arm_rst_done_err", {62'd0, seq_done, cfg_err}, 64'd0);
        check_eq("arm_rst_idx_duty_pat", {cur_idx, duty_num, pat}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin m_pat[i] = '0; m_duty[i] = '0; m_rep[i] = '0; end
        run_case(D - 1, 0, 0, "cleared_table");
        wr(1, 8'hC3, 33, 2);
        run_case(1, 0, 0, "after_reset_run");

        wr(0, 8'hF0, 200, 255);
        run_case(0, 0, 0, "rep_255");

        for (int t = 0; t < 20; t++) begin
            for (int a = 0; a < D; a++)
                wr(a, $urandom_range(255), $urandom_range(255), $urandom_range(3));
            last = $urandom_range(D - 1);
            loop = 1'($urandom_range(1));
            total = 0;
            for (int i = 0; i <= last; i++) total += int'(m_rep[i]);
            if (loop && total > 0) nstop = $urandom_range(2 * total + 1, 1);
            else if (total > 0 && $urandom_range(1) == 1) nstop = $urandom_range(total, 1);
            else nstop = 0;
            run_case(last, loop, nstop, "random_run");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
